// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the sram-like arbiter: FSM states, transaction owner, kseg mask constants.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam int         KSEG_TOP_W = 3;
  localparam logic [2:0] KSEG0_TOP  = 3'b100;
  localparam logic [2:0] KSEG1_TOP  = 3'b101;

endpackage

// File: rtl/sram_like_rr_arb.sv
// Two-request round-robin grant; remembers which master won the last accepted request.
module sram_like_rr_arb
  import sram_like_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic grant_inst_o,
  output logic grant_data_o
);

  owner_e last_q, last_d;

  // Data wins a tie unless it also won last time, so neither master can starve.
  always_comb begin
    grant_data_o = en_i && data_req_i && (!inst_req_i || (last_q != OWN_DATA));
    grant_inst_o = en_i && inst_req_i && !grant_data_o;
    last_d       = last_q;
    if (grant_data_o) begin
      last_d = OWN_DATA;
    end else if (grant_inst_o) begin
      last_d = OWN_INST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= OWN_INST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_like_arbiter.sv
// Arbitrates the core's inst/data sram-like ports onto one single-outstanding valid/ready bus.
// Optional kseg0/kseg1 address folding is enabled by defining SRAM_LIKE_ARBITER_ADDR_MAP_EN.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wr,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  output logic [DATA_W-1:0]   mem_req_wdata,
  input  logic                mem_resp_valid,
  output logic                mem_resp_ready,
  input  logic [DATA_W-1:0]   mem_resp_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                wr_q, wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]   data_rdata_q, data_rdata_d;
  logic                grant_inst, grant_data;
  logic                arb_en;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] m;
    m = a;
`ifdef SRAM_LIKE_ARBITER_ADDR_MAP_EN
    if ((a[ADDR_W-1 -: KSEG_TOP_W] == KSEG0_TOP) || (a[ADDR_W-1 -: KSEG_TOP_W] == KSEG1_TOP)) begin
      m[ADDR_W-1 -: KSEG_TOP_W] = '0;
    end
`endif
    return m;
  endfunction

  // Gating with resetn keeps addr_ok low while reset is asserted, even mid-cycle.
  assign arb_en = (state_q == ST_IDLE) && resetn;

  sram_like_rr_arb u_rr_arb (
    .clk          (clk),
    .rst_n        (resetn),
    .en_i         (arb_en),
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .grant_inst_o (grant_inst),
    .grant_data_o (grant_data)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wstrb_d      = wstrb_q;
    wdata_d      = wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;

    inst_addr_ok   = grant_inst;
    data_addr_ok   = grant_data;
    mem_req_valid  = (state_q == ST_REQ);
    mem_resp_ready = (state_q == ST_RESP);
    inst_data_ok   = (state_q == ST_DONE) && (owner_q == OWN_INST);
    data_data_ok   = (state_q == ST_DONE) && (owner_q == OWN_DATA);

    unique case (state_q)
      ST_IDLE: begin
        if (grant_inst) begin
          owner_d = OWN_INST;
          wr_d    = 1'b0;
          addr_d  = map_addr(inst_addr);
          wstrb_d = '0;
          wdata_d = '0;
          state_d = ST_REQ;
        end else if (grant_data) begin
          owner_d = OWN_DATA;
          wr_d    = data_wr;
          addr_d  = map_addr(data_addr);
          wstrb_d = data_wr ? data_wstrb : '0;
          wdata_d = data_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (mem_resp_valid) begin
          if (owner_q == OWN_INST) begin
            inst_rdata_d = mem_resp_rdata;
          end else if (!wr_q) begin
            data_rdata_d = mem_resp_rdata;
          end
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_INST;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wstrb_q      <= '0;
      wdata_q      <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wstrb_q      <= wstrb_d;
      wdata_q      <= wdata_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem_req_wr    = wr_q;
  assign mem_req_addr  = addr_q;
  assign mem_req_wstrb = wstrb_q;
  assign mem_req_wdata = wdata_q;
  assign inst_rdata    = inst_rdata_q;
  assign data_rdata    = data_rdata_q;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: vector table, hand corner cases, randomized model check.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wr;
  logic [31:0] mem_req_addr;
  logic [3:0]  mem_req_wstrb;
  logic [31:0] mem_req_wdata;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;

  int total = 0;
  int bad   = 0;

  // Behavioural model state: who won last, and what each master's rdata should hold.
  logic        lastData;
  logic [31:0] mIR;
  logic [31:0] mDR;

  typedef struct {
    logic        iReq;
    logic        dReq;
    logic [31:0] iAddr;
    logic [31:0] dAddr;
    logic        dWr;
    logic [3:0]  dStrb;
    logic [31:0] dWdata;
    int          stall;
    int          respDelay;
    logic        junk;
    logic [31:0] respData;
    logic        expData;
    logic [31:0] expAddr;
    logic        expWr;
    logic [3:0]  expStrb;
    logic [31:0] expWdata;
    logic [31:0] expIR;
    logic [31:0] expDR;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  sram_like_arbiter dut (
    .clk            (clk),
    .resetn         (resetn),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_addr_ok   (inst_addr_ok),
    .inst_data_ok   (inst_data_ok),
    .inst_rdata     (inst_rdata),
    .data_req       (data_req),
    .data_wr        (data_wr),
    .data_wstrb     (data_wstrb),
    .data_addr      (data_addr),
    .data_wdata     (data_wdata),
    .data_addr_ok   (data_addr_ok),
    .data_data_ok   (data_data_ok),
    .data_rdata     (data_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_wr     (mem_req_wr),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wstrb  (mem_req_wstrb),
    .mem_req_wdata  (mem_req_wdata),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_rdata (mem_resp_rdata)
  );

  task automatic checkBit(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mapExp(input logic [31:0] a);
`ifdef SRAM_LIKE_ARBITER_ADDR_MAP_EN
    if (a >= 32'h8000_0000 && a <= 32'hBFFF_FFFF) return a & 32'h1FFF_FFFF;
`endif
    return a;
  endfunction

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    inst_req       = 1'b0;
    inst_addr      = 32'h0;
    data_req       = 1'b0;
    data_wr        = 1'b0;
    data_wstrb     = 4'h0;
    data_addr      = 32'h0;
    data_wdata     = 32'h0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
  endtask

  task automatic checkAllZero(input string tag);
    checkBit({tag, " inst_addr_ok"}, inst_addr_ok, 1'b0);
    checkBit({tag, " inst_data_ok"}, inst_data_ok, 1'b0);
    checkWord({tag, " inst_rdata"}, inst_rdata, 32'h0);
    checkBit({tag, " data_addr_ok"}, data_addr_ok, 1'b0);
    checkBit({tag, " data_data_ok"}, data_data_ok, 1'b0);
    checkWord({tag, " data_rdata"}, data_rdata, 32'h0);
    checkBit({tag, " mem_req_valid"}, mem_req_valid, 1'b0);
    checkBit({tag, " mem_req_wr"}, mem_req_wr, 1'b0);
    checkWord({tag, " mem_req_addr"}, mem_req_addr, 32'h0);
    checkWord({tag, " mem_req_wstrb"}, {28'h0, mem_req_wstrb}, 32'h0);
    checkWord({tag, " mem_req_wdata"}, mem_req_wdata, 32'h0);
    checkBit({tag, " mem_resp_ready"}, mem_resp_ready, 1'b0);
  endtask

  // Fill a vector's expectations from the arbitration rule and update the model.
  task automatic buildExp(inout vec_t v);
    logic win;
    win = v.dReq && !(v.iReq && lastData);
    v.expData = win;
    if (win) begin
      v.expAddr  = mapExp(v.dAddr);
      v.expWr    = v.dWr;
      v.expStrb  = v.dWr ? v.dStrb : 4'h0;
      v.expWdata = v.dWdata;
      if (!v.dWr) mDR = v.respData;
      lastData = 1'b1;
    end else begin
      v.expAddr  = mapExp(v.iAddr);
      v.expWr    = 1'b0;
      v.expStrb  = 4'h0;
      v.expWdata = 32'h0;
      mIR = v.respData;
      lastData = 1'b0;
    end
    v.expIR = mIR;
    v.expDR = mDR;
  endtask

  // One full transaction from IDLE: address phase, stalled bus request, delayed response, DONE pulse.
  task automatic applyStimulus(input vec_t v, input string tag);
    inst_req       = v.iReq;
    inst_addr      = v.iAddr;
    data_req       = v.dReq;
    data_addr      = v.dAddr;
    data_wr        = v.dWr;
    data_wstrb     = v.dStrb;
    data_wdata     = v.dWdata;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    #2;
    checkBit({tag, " inst_addr_ok"}, inst_addr_ok, !v.expData);
    checkBit({tag, " data_addr_ok"}, data_addr_ok, v.expData);
    checkBit({tag, " idle mem_req_valid"}, mem_req_valid, 1'b0);
    nextCycle();
    for (int c = 0; c <= v.stall; c++) begin
      mem_req_ready = (c == v.stall);
      if (v.junk && c == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 32'hBAD0_BAD0;
      end else begin
        mem_resp_valid = 1'b0;
      end
      #2;
      checkBit({tag, " mem_req_valid"}, mem_req_valid, 1'b1);
      checkWord({tag, " mem_req_addr"}, mem_req_addr, v.expAddr);
      checkBit({tag, " mem_req_wr"}, mem_req_wr, v.expWr);
      checkWord({tag, " mem_req_wstrb"}, {28'h0, mem_req_wstrb}, {28'h0, v.expStrb});
      if (v.expWr) checkWord({tag, " mem_req_wdata"}, mem_req_wdata, v.expWdata);
      checkBit({tag, " busy addr_ok"}, inst_addr_ok | data_addr_ok, 1'b0);
      checkBit({tag, " req mem_resp_ready"}, mem_resp_ready, 1'b0);
      nextCycle();
    end
    mem_req_ready = 1'b0;
    for (int c = 0; c <= v.respDelay; c++) begin
      mem_resp_valid = (c == v.respDelay);
      mem_resp_rdata = (c == v.respDelay) ? v.respData : 32'h0BAD_0000;
      #2;
      checkBit({tag, " mem_resp_ready"}, mem_resp_ready, 1'b1);
      checkBit({tag, " resp mem_req_valid"}, mem_req_valid, 1'b0);
      checkBit({tag, " early data_ok"}, inst_data_ok | data_data_ok, 1'b0);
      nextCycle();
    end
    mem_resp_valid = 1'b0;
    #2;
    checkBit({tag, " inst_data_ok"}, inst_data_ok, !v.expData);
    checkBit({tag, " data_data_ok"}, data_data_ok, v.expData);
    checkWord({tag, " inst_rdata"}, inst_rdata, v.expIR);
    checkWord({tag, " data_rdata"}, data_rdata, v.expDR);
    checkBit({tag, " done addr_ok"}, inst_addr_ok | data_addr_ok, 1'b0);
    inst_req = 1'b0;
    data_req = 1'b0;
    nextCycle();
    #2;
    checkBit({tag, " data_ok single pulse"}, inst_data_ok | data_data_ok, 1'b0);
    checkWord({tag, " inst_rdata hold"}, inst_rdata, v.expIR);
    checkWord({tag, " data_rdata hold"}, data_rdata, v.expDR);
  endtask

  initial begin
    int aok[$];
    int dok[$];
    logic [31:0] r1;
    logic [31:0] r2;
    vec_t v;
    logic [1:0] rq;

    tbl[0] = '{1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 32'h3C08_0001,
               1'b0, mapExp(32'hBFC0_0000), 1'b0, 4'h0, 32'h0, 32'h3C08_0001, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'h0000_0200, 1'b0, 4'hF, 32'h0, 0, 0, 1'b0, 32'h0000_00D1,
               1'b1, 32'h0000_0200, 1'b0, 4'h0, 32'h0, 32'h3C08_0001, 32'h0000_00D1};
    tbl[2] = '{1'b1, 1'b1, 32'h0000_1004, 32'h0000_0204, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 32'h0000_00A2,
               1'b0, 32'h0000_1004, 1'b0, 4'h0, 32'h0, 32'h0000_00A2, 32'h0000_00D1};
    tbl[3] = '{1'b1, 1'b1, 32'h0000_1008, 32'h0000_0208, 1'b1, 4'hF, 32'h1234_5678, 0, 1, 1'b0, 32'hFFFF_FFFF,
               1'b1, 32'h0000_0208, 1'b1, 4'hF, 32'h1234_5678, 32'h0000_00A2, 32'h0000_00D1};
    tbl[4] = '{1'b1, 1'b1, 32'h9000_000C, 32'h0000_020C, 1'b0, 4'h0, 32'h0, 0, 2, 1'b0, 32'h0000_00A4,
               1'b0, mapExp(32'h9000_000C), 1'b0, 4'h0, 32'h0, 32'h0000_00A4, 32'h0000_00D1};
    tbl[5] = '{1'b0, 1'b1, 32'h0, 32'h0000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF, 3, 0, 1'b1, 32'h0,
               1'b1, 32'h0000_0010, 1'b1, 4'b0011, 32'hDEAD_BEEF, 32'h0000_00A4, 32'h0000_00D1};
    tbl[6] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_0300, 1'b0, 4'h0, 32'h0, 1, 1, 1'b0, 32'h0000_00B6,
               1'b0, 32'h0000_2000, 1'b0, 4'h0, 32'h0, 32'h0000_00B6, 32'h0000_00D1};
    tbl[7] = '{1'b0, 1'b1, 32'h0, 32'hA000_0040, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 32'h0000_00C7,
               1'b1, mapExp(32'hA000_0040), 1'b0, 4'h0, 32'h0, 32'h0000_00B6, 32'h0000_00C7};

    // Reset with both masters requesting: everything must read as zero.
    resetn = 1'b0;
    idleInputs();
    inst_req = 1'b1;
    data_req = 1'b1;
    #12;
    checkAllZero("reset");
    nextCycle();
    idleInputs();
    resetn = 1'b1;
    #2;
    checkAllZero("post reset idle");

    // Vector table: arbitration history and bus behaviour computed by hand.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i], $sformatf("vec%0d", i));
    end
    lastData = 1'b1;
    mIR = 32'h0000_00B6;
    mDR = 32'h0000_00C7;

    // Responses in IDLE with nobody requesting are ignored.
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hFEED_0000;
    for (int c = 0; c < 2; c++) begin
      nextCycle();
      #2;
      checkBit("idle resp data_ok", inst_data_ok | data_data_ok, 1'b0);
      checkBit("idle resp ready", mem_resp_ready, 1'b0);
    end
    checkWord("idle resp data_rdata", data_rdata, mDR);

    // Back-to-back data reads with ready and response held high the whole time.
    r1 = 32'h0;
    r2 = 32'h0;
    data_req      = 1'b1;
    data_wr       = 1'b0;
    data_addr     = 32'h0000_0100;
    mem_req_ready = 1'b1;
    mem_resp_rdata = 32'h11;
    for (int c = 0; c < 12; c++) begin
      if (aok.size() == 1) data_addr = 32'h0000_0104;
      if (aok.size() >= 2) data_req = 1'b0;
      if (dok.size() >= 1) mem_resp_rdata = 32'h22;
      #2;
      if (data_addr_ok) aok.push_back(c);
      if (data_data_ok) begin
        dok.push_back(c);
        if (dok.size() == 1) r1 = data_rdata;
        else r2 = data_rdata;
      end
      nextCycle();
    end
    idleInputs();
    checkWord("b2b addr_ok count", aok.size(), 2);
    checkWord("b2b data_ok count", dok.size(), 2);
    if (aok.size() >= 1) checkWord("b2b first addr_ok cycle", aok[0], 0);
    if (dok.size() >= 1) checkWord("b2b first data_ok cycle", dok[0], 3);
    if (aok.size() >= 2 && dok.size() >= 1) checkWord("b2b second addr_ok cycle", aok[1], dok[0] + 1);
    checkWord("b2b rdata first", r1, 32'h11);
    checkWord("b2b rdata second", r2, 32'h22);
    lastData = 1'b1;
    mDR = 32'h22;

    // Reset asserted while in RESP, then a late response after release.
    #2;
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0400;
    #2;
    checkBit("rst seq addr_ok", inst_addr_ok, 1'b1);
    nextCycle();
    inst_req      = 1'b0;
    mem_req_ready = 1'b1;
    nextCycle();
    mem_req_ready = 1'b0;
    #2;
    checkBit("rst seq in RESP", mem_resp_ready, 1'b1);
    resetn   = 1'b0;
    inst_req = 1'b1;
    data_req = 1'b1;
    #1;
    checkAllZero("mid-RESP reset");
    nextCycle();
    #2;
    checkAllZero("held reset");
    resetn         = 1'b1;
    inst_req       = 1'b0;
    data_req       = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_rdata = 32'hDEAD_DEAD;
    #1;
    checkBit("late resp ready", mem_resp_ready, 1'b0);
    nextCycle();
    mem_resp_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #2;
      checkBit("late resp data_ok", inst_data_ok | data_data_ok, 1'b0);
      checkWord("late resp inst_rdata", inst_rdata, 32'h0);
      nextCycle();
    end
    lastData = 1'b0;
    mIR = 32'h0;
    mDR = 32'h0;
    v = '{1'b1, 1'b0, 32'h0000_0800, 32'h0, 1'b0, 4'h0, 32'h0, 0, 0, 1'b0, 32'h0000_0E01,
          1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0};
    buildExp(v);
    applyStimulus(v, "post-reset inst");

    // Randomized traffic checked against the behavioural model.
    for (int n = 0; n < 40; n++) begin
      rq          = 2'($urandom_range(1, 3));
      v.iReq      = rq[0];
      v.dReq      = rq[1];
      v.iAddr     = $urandom;
      v.dAddr     = $urandom;
      v.dWr       = 1'($urandom_range(0, 1));
      v.dStrb     = 4'($urandom_range(0, 15));
      v.dWdata    = $urandom;
      v.stall     = $urandom_range(0, 3);
      v.respDelay = $urandom_range(0, 2);
      v.junk      = (v.stall > 0) && ($urandom_range(0, 1) == 1);
      v.respData  = $urandom;
      buildExp(v);
      applyStimulus(v, $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Sits directly downstream of the CPU core top level.
- Accepts the core's two sram-like request ports (instruction and data): req/addr_ok for the address phase, data_ok/rdata for the data phase.
- Arbitrates them onto one single-outstanding valid/ready memory bus and returns each response to the master that issued the request.
- Lets the core's fetch and load/store paths share one memory port.

Parameters:
- ADDR_W, 32, address width of both masters and the memory bus.
- DATA_W, 32, data width; the wstrb width is DATA_W/8.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  instruction read request
- inst_addr  in  ADDR_W  instruction address
- inst_addr_ok  out  1  instruction request accepted this cycle
- inst_data_ok  out  1  instruction data valid (one-cycle pulse)
- inst_rdata  out  DATA_W  instruction read data
- data_req  in  1  data request
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte write strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  data read/write complete (one-cycle pulse)
- data_rdata  out  DATA_W  data read data
- mem_req_valid  out  1  bus request valid
- mem_req_ready  in  1  bus request accepted
- mem_req_wr  out  1  bus write flag
- mem_req_addr  out  ADDR_W  bus address
- mem_req_wstrb  out  DATA_W/8  bus strobes (0 for reads)
- mem_req_wdata  out  DATA_W  bus write data
- mem_resp_valid  in  1  bus response (read data or write ack)
- mem_resp_ready  out  1  bus response accepted
- mem_resp_rdata  in  DATA_W  bus read data

Behaviour:
- Clock and reset: one clock, clk. Reset is resetn, asynchronous and active-low.
- Reset values:
  - State is IDLE and last_grant is INST.
  - All outputs are 0, including rdata registers.
  - addr_ok outputs are forced to 0 while resetn is low.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Grant rule when both masters request: data wins, unless last_grant is DATA, in which case inst wins (round-robin, no starvation). A single requester wins outright.
  - The winner's addr_ok is combinationally 1 in the same cycle. The loser's addr_ok is 0.
  - On the handshake: latch owner, wr, addr, wstrb, wdata and update last_grant; go to REQ.
  - Inst requests are always reads: wr = 0, wstrb = 0.
- REQ:
  - mem_req_valid = 1, driven from the latched fields. Fields are stable until the handshake.
  - On mem_req_ready, go to RESP.
- RESP:
  - mem_resp_ready = 1.
  - On mem_resp_valid, register mem_resp_rdata into the owner's rdata register only (writes leave rdata unchanged); go to DONE.
- DONE:
  - The owner's data_ok = 1 for exactly one cycle; go to IDLE.
  - No addr_ok is given in DONE.
- Latency: with ready and response both zero-wait, addr_ok at T, mem_req_valid at T+1, response at T+2, data_ok at T+3, next addr_ok earliest at T+4.
- Outside their states, mem_req_valid and mem_resp_ready are 0, and mem_resp_valid is ignored.
- Only one transaction is outstanding at a time; requests issued while the block is busy are simply not acknowledged.
- The rdata registers hold their value between pulses.
- Asynchronous reset mid-transaction returns to IDLE immediately and no data_ok is produced. A bus response arriving after the reset releases (while not in RESP) is ignored.
- Width rules: addresses pass through unmodified unless ADDR_MAP_EN is defined. No size or alignment checking; masters supply aligned strobes.

Optional Feature:
- Macro: SRAM_LIKE_ARBITER_ADDR_MAP_EN.
- Defined: the latched address is mapped when its top bits are 3'b100 or 3'b101 (kseg0/kseg1, 0x8000_0000–0xBFFF_FFFF). The top 3 bits are cleared, so 0xBFC0_0000 becomes 0x1FC0_0000. All other addresses pass unchanged.
- Not defined: mem_req_addr equals the latched address.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE/REQ/RESP/DONE);
  - the owner encoding (INST/DATA);
  - the kseg mask constants.
- One natural sub-module, sram_like_rr_arb: two-request round-robin grant with the last_grant register. Everything else stays in the top of the block.

Test Plan:
- Inst read only, addr 0xBFC0_0000, bus zero-wait returns 0x3C08_0001 -> inst_addr_ok at T, mem_req_valid at T+1, inst_data_ok at T+3 with inst_rdata = 0x3C08_0001; with the macro on, mem_req_addr = 0x1FC0_0000.
- Data write addr 0x0000_0010, wstrb 4'b0011, wdata 0xDEAD_BEEF; mem_req_ready held low 3 cycles -> mem_req fields stable across the stall; data_data_ok pulses once after the ack; data_rdata unchanged.
- inst_req and data_req both held high for 4 transactions -> grants alternate data, inst, data, inst; each data_ok goes to the correct master with the matching rdata.
- mem_resp_valid pulsed while in IDLE and REQ -> ignored, no data_ok; the transaction completes only on the RESP-state response.
- resetn dropped while in RESP -> all outputs 0 immediately; after release, a late mem_resp_valid produces no data_ok; a next inst request is accepted normally.
- Back-to-back data reads 0x100 then 0x104 (returning 0x11, 0x22) -> the second data_addr_ok comes no earlier than the cycle after the first data_data_ok; data_rdata = 0x11 then 0x22.
